// File: rtl/secded_encoder.sv
// Hamming(8,4) SECDED encoder with a small output FIFO and a wrapping count of emitted codewords.
// Optional error injection on push is enabled by defining SECDED_ERR_INJ_EN.
module secded_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_code,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SECDED_ERR_INJ_EN
  input  logic             inj_en,
  input  logic [7:0]       inj_mask,
`endif
  output logic [CNT_W-1:0] word_cnt
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int AW    = PTR_W - 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count;
  logic [7:0]       mem [DEPTH];
  logic [7:0]       clean_code;
  logic [7:0]       store_code;
  logic             push;
  logic             pop;
  logic             unused_ptr_msb;

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    c[3:0] = d;
    c[4]   = d[0] ^ d[1] ^ d[3];
    c[5]   = d[0] ^ d[2] ^ d[3];
    c[6]   = d[1] ^ d[2] ^ d[3];
    c[7]   = ^c[6:0];
    return c;
  endfunction

  // Pointers wrap at DEPTH, so their top bit never toggles.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign clean_code = encode(in_data);

`ifdef SECDED_ERR_INJ_EN
  assign store_code = inj_en ? (clean_code ^ inj_mask) : clean_code;
`else
  assign store_code = clean_code;
`endif

  assign in_ready       = (count != PTR_W'(DEPTH));
  assign out_valid      = (count != '0);
  assign push           = in_valid && in_ready;
  assign pop            = out_valid && out_ready;
  assign out_code       = mem[rd_ptr[AW-1:0]];
  assign unused_ptr_msb = rd_ptr[PTR_W-1] ^ wr_ptr[PTR_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      word_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= store_code;
        wr_ptr              <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr   <= next_ptr(rd_ptr);
        word_cnt <= word_cnt + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + PTR_W'(1);
        2'b01:   count <= count - PTR_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
